// File: rtl/bp_trace_arbiter_if.sv
// Trace message type and the handshake bundle shared by the trace arbiter,
// its per-core encoder FIFOs and the off-core trace sink.

package nexus_trace_pkg;

    // One Nexus trace message. src_id is rewritten by the arbiter with the
    // index of the source that won the port.
    typedef struct packed {
        logic [1:0]  src_id;
        logic [15:0] timestamp;
        logic [5:0]  mcode;
        logic [31:0] addr;
    } nexus_trace_pkt_s;

endpackage

// Handshake rule for every channel in this bundle: a message transfers on a
// rising clock edge where valid and ready are both 1. A producer holds its
// payload and valid stable until that edge, and must never make valid
// depend on ready. Ready may depend combinationally on valid.
interface bp_trace_arbiter_if #(parameter int num_src_p = 4);
    import nexus_trace_pkg::*;

    nexus_trace_pkt_s [num_src_p-1:0] src_pkt_i;
    logic [num_src_p-1:0]             src_valid_i;
    logic [num_src_p-1:0]             src_ready_o;
    nexus_trace_pkt_s                 trace_pkt_o;
    logic                             trace_valid_o;
    logic                             trace_ready_i;

    // Arbiter side.
    modport slave (
        input  src_pkt_i, src_valid_i, trace_ready_i,
        output src_ready_o, trace_pkt_o, trace_valid_o
    );

    // Encoders plus sink side.
    modport master (
        output src_pkt_i, src_valid_i, trace_ready_i,
        input  src_ready_o, trace_pkt_o, trace_valid_o
    );

endinterface

// File: rtl/bp_trace_arbiter.sv
// Round-robin arbiter sharing the single off-core trace port between up to
// four trace encoders. Winner's message is registered in a one-entry
// holding register with its src_id stamped. While tracing is disabled all
// sources are drained and the discarded messages are counted.

module bp_trace_arbiter
    import nexus_trace_pkg::*;
#(
    parameter int num_src_p = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    bp_trace_arbiter_if.slave    bus,
    output logic [15:0]          drop_cnt_o
);

    // Holding register and arbitration state.
    logic             full_r;
    nexus_trace_pkt_s pkt_r;
    logic [1:0]       last_grant_r;
    logic [15:0]      drop_cnt_r;

    // Sources widened to four lanes so the search can index with 2 bits.
    nexus_trace_pkt_s pkt_ext [4];
    logic [3:0]       valid_ext;

    logic             load_ok;
    logic             found;
    logic [1:0]       winner;
    logic [2:0]       cand;
    logic             load;
    logic [3:0]       ready_ext;
    nexus_trace_pkt_s win_pkt;
    logic [16:0]      drop_sum;

    for (genvar g = 0; g < 4; g++) begin : g_ext
        if (g < num_src_p) begin : g_real
            assign pkt_ext[g]   = bus.src_pkt_i[g];
            assign valid_ext[g] = bus.src_valid_i[g];
        end else begin : g_pad
            assign pkt_ext[g]   = '0;
            assign valid_ext[g] = 1'b0;
        end
    end

    // A full register that is draining this cycle can take a new message.
    assign load_ok = !full_r || bus.trace_ready_i;

    // Search last_grant_r+1, +2, ... modulo num_src_p; first valid wins.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_r;
        cand   = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = {1'b0, last_grant_r} + 3'(k);
            if (cand >= 3'(num_src_p)) begin
                cand = cand - 3'(num_src_p);
            end
            if ((k <= num_src_p) && !found && valid_ext[cand[1:0]]) begin
                found  = 1'b1;
                winner = cand[1:0];
            end
        end
    end

    assign load = enable_i && load_ok && found;

    // Disabled: accept everything so encoders never stall. Enabled: one-hot
    // on the winner only when the holding register can take it.
    always_comb begin
        ready_ext = 4'h0;
        if (!enable_i) begin
            ready_ext = 4'hF;
        end else if (load_ok && found) begin
            ready_ext = 4'b0001 << winner;
        end
    end

    assign bus.src_ready_o = ready_ext[num_src_p-1:0];

    // Winner's message with its source index stamped in; other fields pass.
    always_comb begin
        win_pkt        = pkt_ext[winner];
        win_pkt.src_id = winner;
    end

    // Holding register: load the winner, otherwise drain when the sink takes it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_r       <= 1'b0;
            pkt_r        <= '0;
            last_grant_r <= 2'(num_src_p - 1);
        end else if (load) begin
            pkt_r        <= win_pkt;
            full_r       <= 1'b1;
            last_grant_r <= winner;
        end else if (bus.trace_ready_i) begin
            full_r       <= 1'b0;
        end
    end

    assign drop_sum = {1'b0, drop_cnt_r} + 17'($countones(bus.src_valid_i));

    // Count every message discarded while disabled; pin at all-ones.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop_cnt_r <= '0;
        end else if (!enable_i) begin
            drop_cnt_r <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign bus.trace_pkt_o   = pkt_r;
    assign bus.trace_valid_o = full_r;
    assign drop_cnt_o        = drop_cnt_r;

endmodule

// File: tb/tb_bp_trace_arbiter.sv
// Directed bench for bp_trace_arbiter. Expected output messages are queued
// when stimulus is applied; a monitor pops and compares each delivered one.

module tb_bp_trace_arbiter;
    import nexus_trace_pkg::*;

    localparam int N  = 4;
    localparam int PW = $bits(nexus_trace_pkt_s);

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b1;
    logic [15:0] drop_cnt_o;

    bp_trace_arbiter_if #(.num_src_p(N)) bus ();

    bp_trace_arbiter #(.num_src_p(N)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .bus        (bus),
        .drop_cnt_o (drop_cnt_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic nexus_trace_pkt_s mk(input logic [1:0] id, input logic [15:0] ts,
                                            input logic [5:0] mc, input logic [31:0] a);
        nexus_trace_pkt_s p;
        p.src_id    = id;
        p.timestamp = ts;
        p.mcode     = mc;
        p.addr      = a;
        return p;
    endfunction

    // Monitor: every delivered message must match the head of the queue.
    always @(negedge clk_i) begin
        if (!reset_i && bus.trace_valid_o && bus.trace_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", 64'(bus.trace_pkt_o), 64'hDEAD);
            end else begin
                check("delivered_pkt", 64'(bus.trace_pkt_o), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    // ---------------- stimulus ----------------
    nexus_trace_pkt_s pa, pb1, pb3, pc, pd;
    logic [1:0] rr_ids [8];

    initial begin
        bus.src_pkt_i     = '0;
        bus.src_valid_i   = '0;
        bus.trace_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // Reset state.
        sample();
        check("reset_valid", 64'(bus.trace_valid_o), 64'd0);
        check("reset_pkt", 64'(bus.trace_pkt_o), 64'd0);
        check("reset_drop", 64'(drop_cnt_o), 64'd0);

        // Round robin from reset: 0,1,2,3,0,1,2,3 with no bubbles.
        tick();
        for (int s = 0; s < N; s++) begin
            bus.src_pkt_i[s] = mk(2'd0, 16'(16'h0100 + s), 6'(s + 1), 32'(32'h1000 + s));
        end
        bus.src_valid_i = 4'b1111;
        rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int c = 0; c < 8; c++) begin
            sample();
            check("rr_ready", 64'(bus.src_ready_o), 64'(4'b0001 << rr_ids[c]));
            if (c > 0) check("rr_no_bubble", 64'(bus.trace_valid_o), 64'd1);
            exp_q.push_back(mk(rr_ids[c], 16'(16'h0100 + rr_ids[c]), 6'(rr_ids[c] + 1),
                               32'(32'h1000 + rr_ids[c])));
            tick();
        end
        bus.src_valid_i = '0;
        sample();
        tick();

        // Single source 2 with src_id 0 in the message; last winner is 3.
        bus.src_pkt_i[2] = mk(2'd0, 16'h1111, 6'h03, 32'h40);
        bus.src_valid_i  = 4'b0100;
        sample();
        check("single_ready", 64'(bus.src_ready_o), 64'b0100);
        exp_q.push_back(mk(2'd2, 16'h1111, 6'h03, 32'h40));
        tick();
        bus.src_valid_i = '0;
        sample();
        check("single_valid", 64'(bus.trace_valid_o), 64'd1);
        tick();
        sample();
        check("single_drained", 64'(bus.trace_valid_o), 64'd0);
        tick();

        // Backpressure: load source 1 with sink stalled (last winner 2 -> 3,0,1).
        pa = mk(2'd0, 16'hAAAA, 6'h0A, 32'hA000);
        bus.trace_ready_i = 1'b0;
        bus.src_pkt_i[1]  = pa;
        bus.src_valid_i   = 4'b0010;
        sample();
        check("bp_first_ready", 64'(bus.src_ready_o), 64'b0010);
        exp_q.push_back(mk(2'd1, 16'hAAAA, 6'h0A, 32'hA000));
        tick();
        pb1 = mk(2'd0, 16'hB001, 6'h11, 32'hB100);
        pb3 = mk(2'd0, 16'hB003, 6'h13, 32'hB300);
        bus.src_pkt_i[1] = pb1;
        bus.src_pkt_i[3] = pb3;
        bus.src_valid_i  = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("bp_stall_ready", 64'(bus.src_ready_o), 64'd0);
            check("bp_stall_pkt", 64'(bus.trace_pkt_o), 64'(mk(2'd1, 16'hAAAA, 6'h0A, 32'hA000)));
            tick();
        end
        bus.trace_ready_i = 1'b1;
        sample();
        check("bp_release_ready", 64'(bus.src_ready_o), 64'b1000);
        exp_q.push_back(mk(2'd3, 16'hB003, 6'h13, 32'hB300));
        tick();
        bus.src_valid_i = 4'b0010;
        sample();
        check("bp_next_ready", 64'(bus.src_ready_o), 64'b0010);
        exp_q.push_back(mk(2'd1, 16'hB001, 6'h11, 32'hB100));
        tick();
        bus.src_valid_i = '0;
        sample();
        tick();

        // Drop count: sources 0,1,3 valid for 5 cycles while disabled.
        enable_i        = 1'b0;
        bus.src_valid_i = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            sample();
            check("drop_ready", 64'(bus.src_ready_o), 64'hF);
            check("drop_no_valid", 64'(bus.trace_valid_o), 64'd0);
            tick();
        end
        enable_i        = 1'b1;
        bus.src_valid_i = '0;
        sample();
        check("drop_cnt_15", 64'(drop_cnt_o), 64'd15);
        tick();

        // Saturation: 15 + 4*16379 = 0xFFFB, one more cycle reaches 0xFFFF.
        enable_i        = 1'b0;
        bus.src_valid_i = 4'b1111;
        repeat (16379) tick();
        sample();
        check("drop_cnt_fffb", 64'(drop_cnt_o), 64'hFFFB);
        tick();
        sample();
        check("drop_cnt_sat", 64'(drop_cnt_o), 64'hFFFF);
        repeat (3) tick();
        sample();
        check("drop_cnt_hold", 64'(drop_cnt_o), 64'hFFFF);
        tick();

        // Disable while full: last winner 1, only source 1 valid.
        enable_i          = 1'b1;
        bus.trace_ready_i = 1'b0;
        pc = mk(2'd3, 16'hC0C0, 6'h2C, 32'hC000);
        bus.src_pkt_i[1]  = pc;
        bus.src_valid_i   = 4'b0010;
        sample();
        check("dis_load_ready", 64'(bus.src_ready_o), 64'b0010);
        exp_q.push_back(mk(2'd1, 16'hC0C0, 6'h2C, 32'hC000));
        tick();
        bus.src_valid_i = '0;
        enable_i        = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sample();
            check("dis_retained_valid", 64'(bus.trace_valid_o), 64'd1);
            check("dis_retained_pkt", 64'(bus.trace_pkt_o), 64'(mk(2'd1, 16'hC0C0, 6'h2C, 32'hC000)));
            tick();
        end
        bus.trace_ready_i = 1'b1;
        sample();
        tick();
        sample();
        check("dis_delivered_once", 64'(bus.trace_valid_o), 64'd0);
        tick();

        // Async reset mid-stream.
        enable_i          = 1'b1;
        bus.trace_ready_i = 1'b0;
        pd = mk(2'd0, 16'hD0D0, 6'h3D, 32'hD000);
        bus.src_pkt_i[3]  = pd;
        bus.src_valid_i   = 4'b1000;
        sample();
        check("rst_pre_ready", 64'(bus.src_ready_o), 64'b1000);
        exp_q.push_back(mk(2'd3, 16'hD0D0, 6'h3D, 32'hD000));
        tick();
        bus.src_valid_i = '0;
        sample();
        check("rst_pre_valid", 64'(bus.trace_valid_o), 64'd1);
        #2 reset_i = 1'b1;
        #1;
        check("rst_async_valid", 64'(bus.trace_valid_o), 64'd0);
        check("rst_async_drop", 64'(drop_cnt_o), 64'd0);
        check("rst_async_pkt", 64'(bus.trace_pkt_o), 64'd0);
        exp_q.delete();
        tick();
        reset_i           = 1'b0;
        bus.trace_ready_i = 1'b1;
        bus.src_pkt_i[1]  = mk(2'd0, 16'hE001, 6'h01, 32'hE100);
        bus.src_pkt_i[2]  = mk(2'd0, 16'hE002, 6'h02, 32'hE200);
        bus.src_pkt_i[3]  = mk(2'd0, 16'hE003, 6'h03, 32'hE300);
        bus.src_valid_i   = 4'b1110;
        sample();
        check("post_rst_ready", 64'(bus.src_ready_o), 64'b0010);
        exp_q.push_back(mk(2'd1, 16'hE001, 6'h01, 32'hE100));
        tick();
        bus.src_valid_i = '0;

        // Bounded drain of the scoreboard.
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_trace_arbiter.md
# bp_trace_arbiter

Round-robin arbiter that shares the single off-core trace port between up to four trace encoders, each producing `nexus_trace_pkt_s` messages with a valid/ready handshake. It sits between the per-core encoder FIFOs and the trace sink. It stamps each forwarded message's `src_id` with the index of the winning source. A trace-enable control lets software stop tracing without stalling the cores: while disabled, incoming messages are drained and counted as dropped.

## Interface
Parameters:
- `num_src_p`, 4: number of requesting encoders, legal range 1..4 (bounded by the 2-bit `src_id`).

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_i`  in  1  reset, asynchronous and active-high.
- `enable_i`  in  1  trace enable; 1 = arbitrate and forward, 0 = accept and drop.
- `src_pkt_i`  in  `num_src_p` x `$bits(nexus_trace_pkt_s)`  per-source message.
- `src_valid_i`  in  `num_src_p`  per-source valid.
- `src_ready_o`  out  `num_src_p`  per-source ready; a transfer occurs when valid && ready.
- `trace_pkt_o`  out  `$bits(nexus_trace_pkt_s)`  forwarded message, registered.
- `trace_valid_o`  out  1  output holding register full.
- `trace_ready_i`  in  1  sink accepts `trace_pkt_o` this cycle.
- `drop_cnt_o`  out  16  count of messages dropped while disabled; saturates.

## Operation
- Output is a one-entry holding register (`full_r`, `pkt_r`).
- `load_ok` = !`full_r` || `trace_ready_i`. A full register that drains can reload in the same cycle.
- Pointer `last_grant_r` holds the index of the most recent winner.
- Grant order: search indices `last_grant_r`+1, +2, … modulo `num_src_p`. The first source with `src_valid_i` set wins.
- Enabled (`enable_i`=1):
  - If `load_ok` and any source is valid, `src_ready_o` is one-hot on the winner and all other readies are 0.
  - `pkt_r` <= winner's packet, with `src_id` overwritten by the winner index. All other fields (`timestamp`, `mcode`, `addr`) pass through unmodified.
  - `full_r` <= 1 and `last_grant_r` <= winner.
- Enabled, `load_ok`=0: all `src_ready_o` are 0; `pkt_r`, `full_r` and `last_grant_r` hold.
- Enabled, no source valid: `src_ready_o` = 0. `full_r` clears if the sink drains it. Pointer holds.
- Disabled (`enable_i`=0):
  - `src_ready_o` is all ones; every valid source is consumed and discarded.
  - `drop_cnt_o` += popcount(`src_valid_i`), saturating at 0xFFFF.
  - No new load occurs and the pointer holds.
  - A message already in `pkt_r` is retained and still delivered normally.
- `src_ready_o` depends combinationally on `src_valid_i`, `enable_i`, `trace_ready_i` and state. Sources must not make `src_valid_i` depend on `src_ready_o`.
- Sources must hold packet and valid stable until accepted. The arbiter never drops a message while enabled.

## Timing
- Reset values: `trace_valid_o`=0, `trace_pkt_o`=0, `drop_cnt_o`=0, `last_grant_r`=`num_src_p`-1 (source 0 has first priority).
- Reset is asynchronous: outputs clear immediately on `reset_i` assertion, including mid-transfer. Any held message is lost, and the lost message is not counted as dropped.
- Latency: a source accepted in cycle N appears on `trace_pkt_o` with `trace_valid_o`=1 in cycle N+1.
- Throughput: one message per cycle sustained while `trace_ready_i`=1.
- Fairness: with all sources continuously valid and no stall, each source wins exactly once every `num_src_p` cycles.
- Stall: while `trace_valid_o`=1 and `trace_ready_i`=0, `trace_pkt_o` is stable.
- `enable_i` is sampled each cycle with no hysteresis. A 1→0 change takes effect in the same cycle.
- Saturation: once `drop_cnt_o` reaches 0xFFFF it holds until reset. It never wraps to 0.

## Test plan
- Single source: after reset, `num_src_p`=4. Source 2 presents addr 0x40 with `src_id`=0, `trace_ready_i`=1 → `src_ready_o`=4'b0100 in the same cycle. Next cycle `trace_valid_o`=1, `src_id`=2, addr=0x40.
- Round robin: all 4 sources continuously valid, `trace_ready_i`=1 for 8 cycles → output `src_id` sequence is 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: output full, `trace_ready_i`=0 for 3 cycles → `src_ready_o`=0 and `trace_pkt_o` unchanged. Then `trace_ready_i`=1 with sources 1 and 3 valid and last winner 1 → source 3 loads in that same cycle.
- Drop count: `enable_i`=0, sources 0, 1, 3 valid for 5 cycles → `drop_cnt_o`=15 and `trace_valid_o` stays 0. Preloading the count near 0xFFFF via a long run → it stops at 0xFFFF.
- Disable while full: `pkt_r` holds the source-1 message, `trace_ready_i`=0, then `enable_i` drops → message retained. When `trace_ready_i`=1 it is delivered once, after which `trace_valid_o`=0.
- Async reset mid-stream: assert `reset_i` between clock edges while `trace_valid_o`=1 → `trace_valid_o`=0 and `drop_cnt_o`=0 immediately. After release, the first grant goes to the lowest-index valid source.
